// File: rtl/writeback_stage.sv
// Writeback stage: a single-entry register between the memory stage and the
// register file. Load data is formatted here. The stage drives a one-cycle
// register-file write pulse, a forwarding view of the held entry and a
// commit bundle that holds the last retired instruction.
// The load formatter assumes XLEN >= 32.
module writeback_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    input  logic            hold,

    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic [4:0]      in_rd,
    input  logic            in_rd_we,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic            in_is_load,
    input  logic [1:0]      in_load_size,
    input  logic            in_load_unsigned,
    input  logic [XLEN-1:0] in_mem_rdata,
    input  logic [2:0]      in_addr_low,
    input  logic            in_jump_valid,
    input  logic [XLEN-1:0] in_jump_target,
    input  logic            in_difftest_skip,

    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,

    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data,

    output logic [XLEN-1:0] commit_inst_counter,
    output logic [31:0]     commit_inst,
    output logic [XLEN-1:0] commit_pc,
    output logic            commit_jump_valid,
    output logic [XLEN-1:0] commit_jump_target,
    output logic            commit_difftest_skip
);

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    logic            w_accept;
    logic            w_writes_rf;
    logic            w_sign_en;
    logic [2:0]      w_lane_mask;
    logic [2:0]      w_offset;
    logic [XLEN-1:0] w_shifted;
    logic [XLEN-1:0] w_load_data;
    logic [XLEN-1:0] w_result;

    logic            r_valid;
    logic            r_wb_pending;
    logic [4:0]      r_rd;
    logic            r_rd_we;
    logic [XLEN-1:0] r_result;
    logic [XLEN-1:0] r_commit_inst_counter;
    logic [31:0]     r_inst;
    logic [XLEN-1:0] r_pc;
    logic            r_jump_valid;
    logic [XLEN-1:0] r_jump_target;
    logic            r_difftest_skip;

    // hold dominates flush for readiness; flush only suppresses acceptance.
    assign in_ready    = !hold;
    assign w_accept    = in_valid && in_ready && !flush;
    assign w_writes_rf = in_rd_we && (in_rd != 5'd0);

    // Align the addressed lane to bit 0 and size/sign-extend it.
    always_comb begin
        w_lane_mask = 3'b000;
        w_load_data = '0;
        case (in_load_size)
            SIZE_B:  w_lane_mask = 3'b111;
            SIZE_H:  w_lane_mask = 3'b110;
            SIZE_W:  w_lane_mask = 3'b100;
            default: w_lane_mask = 3'b000;
        endcase
        w_offset  = in_addr_low & w_lane_mask;
        w_shifted = in_mem_rdata >> {w_offset, 3'b000};
        w_sign_en = !in_load_unsigned;
        case (in_load_size)
            SIZE_B:  w_load_data = {{(XLEN-8){w_sign_en & w_shifted[7]}},   w_shifted[7:0]};
            SIZE_H:  w_load_data = {{(XLEN-16){w_sign_en & w_shifted[15]}}, w_shifted[15:0]};
            SIZE_W:  w_load_data = {{(XLEN-32){w_sign_en & w_shifted[31]}}, w_shifted[31:0]};
            default: w_load_data = w_shifted;
        endcase
        w_result = in_is_load ? w_load_data : in_alu_result;
    end

    // Entry occupancy and the one-shot register-file write pulse.
    // The pulse never survives a second cycle of the same entry, held or not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_wb_pending <= 1'b0;
        end else if (w_accept) begin
            r_valid      <= 1'b1;
            r_wb_pending <= w_writes_rf;
        end else begin
            r_valid      <= hold ? r_valid : 1'b0;
            r_wb_pending <= 1'b0;
        end
    end

    // Writeback payload of the held entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd     <= '0;
            r_rd_we  <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_rd     <= in_rd;
            r_rd_we  <= in_rd_we;
            r_result <= w_result;
        end
    end

    // Commit bundle: survives the entry going invalid, changes only on acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst          <= '0;
            r_pc            <= '0;
            r_jump_valid    <= 1'b0;
            r_jump_target   <= '0;
            r_difftest_skip <= 1'b0;
        end else if (w_accept) begin
            r_inst          <= in_inst;
            r_pc            <= in_pc;
            r_jump_valid    <= in_jump_valid;
            r_jump_target   <= in_jump_target;
            r_difftest_skip <= in_difftest_skip;
        end
    end

    // Retired-instruction counter; wraps naturally at 2^XLEN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_commit_inst_counter <= '0;
        end else if (w_accept) begin
            r_commit_inst_counter <= r_commit_inst_counter + 1'b1;
        end
    end

    assign rf_we    = r_wb_pending;
    assign rf_waddr = r_rd;
    assign rf_wdata = r_result;

    assign fwd_valid = r_valid && r_rd_we && (r_rd != 5'd0);
    assign fwd_rd    = r_rd;
    assign fwd_data  = r_result;

    assign commit_inst_counter  = r_commit_inst_counter;
    assign commit_inst          = r_inst;
    assign commit_pc            = r_pc;
    assign commit_jump_valid    = r_jump_valid;
    assign commit_jump_target   = r_jump_target;
    assign commit_difftest_skip = r_difftest_skip;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios followed by random traffic,
// all compared against a transaction-level reference model.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush, hold;
    logic [31:0] in_inst;
    logic [63:0] in_pc, in_alu_result, in_mem_rdata, in_jump_target;
    logic [4:0]  in_rd;
    logic        in_rd_we, in_is_load, in_load_unsigned, in_jump_valid, in_difftest_skip;
    logic [1:0]  in_load_size;
    logic [2:0]  in_addr_low;
    logic        rf_we, fwd_valid, commit_jump_valid, commit_difftest_skip;
    logic [4:0]  rf_waddr, fwd_rd;
    logic [63:0] rf_wdata, fwd_data, commit_inst_counter, commit_pc, commit_jump_target;
    logic [31:0] commit_inst;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: what the stage should be showing right now.
    logic        m_valid, m_pulse, m_rd_we, m_jv, m_skip;
    logic [4:0]  m_rd;
    logic [63:0] m_result, m_cnt, m_pc, m_jt;
    logic [31:0] m_inst;

    writeback_stage #(.XLEN(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush), .hold(hold),
        .in_inst(in_inst), .in_pc(in_pc), .in_rd(in_rd), .in_rd_we(in_rd_we),
        .in_alu_result(in_alu_result), .in_is_load(in_is_load),
        .in_load_size(in_load_size), .in_load_unsigned(in_load_unsigned),
        .in_mem_rdata(in_mem_rdata), .in_addr_low(in_addr_low),
        .in_jump_valid(in_jump_valid), .in_jump_target(in_jump_target),
        .in_difftest_skip(in_difftest_skip),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .commit_inst_counter(commit_inst_counter), .commit_inst(commit_inst),
        .commit_pc(commit_pc), .commit_jump_valid(commit_jump_valid),
        .commit_jump_target(commit_jump_target),
        .commit_difftest_skip(commit_difftest_skip)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Load formatting from first principles: size in bytes, aligned lane, extend.
    function automatic logic [63:0] ref_load(input logic [63:0] rdata, input logic [1:0] size,
                                             input logic [2:0] addr, input logic uns);
        int          nbytes = 1 << size;
        int          off    = (int'(addr) / nbytes) * nbytes;
        int          nbits  = nbytes * 8;
        logic [63:0] v      = rdata >> (off * 8);
        logic [63:0] lowmask;
        if (nbits < 64) begin
            lowmask = (64'd1 << nbits) - 64'd1;
            v = v & lowmask;
            if (!uns && v[nbits-1]) v = v | ~lowmask;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_pulse = 0; m_rd_we = 0; m_jv = 0; m_skip = 0;
        m_rd = 0; m_result = 0; m_cnt = 0; m_pc = 0; m_jt = 0; m_inst = 0;
    endtask

    // One clock edge of the reference: a transaction either retires or it does not.
    task automatic model_clock();
        if (in_valid && !hold && !flush) begin
            m_valid  = 1;
            m_pulse  = in_rd_we && (in_rd != 0);
            m_rd     = in_rd;
            m_rd_we  = in_rd_we;
            m_result = in_is_load ? ref_load(in_mem_rdata, in_load_size, in_addr_low, in_load_unsigned)
                                  : in_alu_result;
            m_cnt    = m_cnt + 64'd1;
            m_inst   = in_inst;
            m_pc     = in_pc;
            m_jv     = in_jump_valid;
            m_jt     = in_jump_target;
            m_skip   = in_difftest_skip;
        end else begin
            m_pulse = 0;
            if (!hold) m_valid = 0;
        end
    endtask

    task automatic check_outputs();
        check_eq("rf_we", rf_we, m_pulse);
        check_eq("fwd_valid", fwd_valid, m_valid && m_rd_we && (m_rd != 0));
        check_eq("counter", commit_inst_counter, m_cnt);
        check_eq("commit_inst", commit_inst, m_inst);
        check_eq("commit_pc", commit_pc, m_pc);
        check_eq("commit_jv", commit_jump_valid, m_jv);
        check_eq("commit_jt", commit_jump_target, m_jt);
        check_eq("commit_skip", commit_difftest_skip, m_skip);
        if (m_valid) begin
            check_eq("rf_waddr", rf_waddr, m_rd);
            check_eq("rf_wdata", rf_wdata, m_result);
            check_eq("fwd_rd", fwd_rd, m_rd);
            check_eq("fwd_data", fwd_data, m_result);
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic cycle();
        #1 check_eq("in_ready", in_ready, !hold);
        @(posedge clk);
        model_clock();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        in_valid = 0; hold = 0; flush = 0;
    endtask

    task automatic set_alu(input logic [4:0] rd, input logic we, input logic [63:0] val,
                           input logic [63:0] pc);
        in_valid = 1; hold = 0; flush = 0;
        in_rd = rd; in_rd_we = we; in_alu_result = val; in_pc = pc;
        in_is_load = 0; in_inst = $urandom; in_jump_valid = $urandom_range(0, 1);
        in_jump_target = {$urandom, $urandom}; in_difftest_skip = $urandom_range(0, 1);
    endtask

    task automatic set_load(input logic [1:0] size, input logic uns, input logic [2:0] addr);
        set_alu(5'd7, 1'b1, 64'hDEAD_BEEF_0BAD_F00D, 64'h8000_0100);
        in_is_load = 1; in_load_size = size; in_load_unsigned = uns; in_addr_low = addr;
        in_mem_rdata = 64'h8877665544332211;
    endtask

    initial begin
        logic [63:0] cnt_before;
        int          pulses;
        rst = 1; idle();
        in_inst = 0; in_pc = 0; in_rd = 0; in_rd_we = 0; in_alu_result = 0; in_is_load = 0;
        in_load_size = 0; in_load_unsigned = 0; in_mem_rdata = 0; in_addr_low = 0;
        in_jump_valid = 0; in_jump_target = 0; in_difftest_skip = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        check_eq("reset_waddr", rf_waddr, 0);
        check_eq("reset_wdata", rf_wdata, 0);
        rst = 0;

        // Basic ALU writeback and single-cycle pulse.
        set_alu(5'd5, 1'b1, 64'h1234, 64'h8000_0000);
        cycle();
        check_eq("alu_rf_we", rf_we, 1);
        check_eq("alu_waddr", rf_waddr, 5);
        check_eq("alu_wdata", rf_wdata, 64'h1234);
        check_eq("alu_cnt", commit_inst_counter, 1);
        check_eq("alu_pc", commit_pc, 64'h8000_0000);
        idle(); cycle();
        check_eq("alu_rf_we_drop", rf_we, 0);
        check_eq("alu_cnt_hold", commit_inst_counter, 1);

        // Load formatting.
        set_load(2'd1, 1'b0, 3'd6); cycle();
        check_eq("ld_h_signed", rf_wdata, 64'hFFFF_FFFF_FFFF_8877);
        set_load(2'd0, 1'b0, 3'd5); cycle();
        check_eq("ld_b_signed", rf_wdata, 64'h66);
        set_load(2'd2, 1'b1, 3'd4); cycle();
        check_eq("ld_w_unsigned", rf_wdata, 64'h8877_6655);
        set_load(2'd2, 1'b0, 3'd7); cycle();
        check_eq("ld_w_misalign", rf_wdata, 64'hFFFF_FFFF_8877_6655);
        set_load(2'd3, 1'b0, 3'd5); cycle();
        check_eq("ld_d", rf_wdata, 64'h8877665544332211);
        idle(); cycle();

        // rd = 0 still retires but never writes or forwards.
        cnt_before = commit_inst_counter;
        set_alu(5'd0, 1'b1, 64'h55, 64'h8000_0200); cycle();
        check_eq("rd0_rf_we", rf_we, 0);
        check_eq("rd0_fwd", fwd_valid, 0);
        check_eq("rd0_cnt", commit_inst_counter, cnt_before + 1);
        check_eq("rd0_pc", commit_pc, 64'h8000_0200);

        // Flush drops the entry with no state change.
        cnt_before = commit_inst_counter;
        set_alu(5'd9, 1'b1, 64'h99, 64'h8000_0300); flush = 1; cycle();
        check_eq("flush_cnt", commit_inst_counter, cnt_before);
        check_eq("flush_pc", commit_pc, 64'h8000_0200);
        check_eq("flush_rf_we", rf_we, 0);

        // Hold for three cycles: one pulse, forwarding persists.
        set_alu(5'd3, 1'b1, 64'hABCD, 64'h8000_0400); cycle();
        pulses = rf_we ? 1 : 0;
        set_alu(5'd4, 1'b1, 64'h1111, 64'h8000_0500); hold = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (rf_we) pulses++;
            check_eq("hold_fwd", fwd_valid, 1);
            check_eq("hold_ready", in_ready, 0);
        end
        check_eq("hold_pulses", pulses, 1);
        check_eq("hold_fwd_data", fwd_data, 64'hABCD);
        flush = 1; cycle();
        check_eq("holdflush_pc", commit_pc, 64'h8000_0400);
        idle(); cycle();
        check_eq("drop_fwd", fwd_valid, 0);

        // Counter wrap from all-ones.
        force dut.r_commit_inst_counter = {64{1'b1}};
        #1 release dut.r_commit_inst_counter;
        m_cnt = {64{1'b1}};
        #1 check_eq("forced_cnt", commit_inst_counter, {64{1'b1}});
        @(negedge clk);
        set_alu(5'd6, 1'b1, 64'h66, 64'h8000_0600); cycle();
        check_eq("wrap_cnt", commit_inst_counter, 0);

        // Reset in the middle of a freshly accepted entry.
        set_alu(5'd10, 1'b1, 64'h77, 64'h8000_0700);
        #1 @(posedge clk);
        model_clock();
        #2 rst = 1;
        model_reset();
        #1 check_outputs();
        check_eq("rst_rf_we", rf_we, 0);
        check_eq("rst_wdata", rf_wdata, 0);
        idle();
        @(negedge clk);
        rst = 0;
        set_alu(5'd11, 1'b1, 64'h88, 64'h8000_0800); cycle();
        check_eq("post_rst_cnt", commit_inst_counter, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            set_alu(($urandom % 4 == 0) ? 5'd0 : 5'($urandom), 1'($urandom), {$urandom, $urandom},
                    {$urandom, $urandom});
            in_valid         = ($urandom % 4) != 0;
            hold             = ($urandom % 6) == 0;
            flush            = ($urandom % 8) == 0;
            in_is_load       = 1'($urandom);
            in_load_size     = 2'($urandom);
            in_load_unsigned = 1'($urandom);
            in_addr_low      = 3'($urandom);
            in_mem_rdata     = {$urandom, $urandom};
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
